pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Parametrised successor of the single-cycle program counter. Holds the architectural PC, issues fetch requests over a valid/ready handshake, and applies next-PC updates from execute.
- Adds optional compressed-instruction support, flush/redirect, misaligned-target detection with halt, and a retired-update counter.
- Sits between decode/execute and the instruction memory port.

Parameters:
- XLEN, 32, data/address width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset; must be aligned (elaboration assertion).
- C_EXT, 0, 1 = 2-byte instruction alignment and 2-byte increments allowed; 0 = 4-byte only.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op  in  3  PC operation, encoded per pc_pkg
- op_valid  in  1  execute presents op for the instruction at data
- br_taken  in  1  branch condition, used only for PC_BRANCH
- ilen_c  in  1  current instruction is 16-bit; ignored when C_EXT=0
- dec_imm  in  XLEN  decoded immediate
- alu_res  in  XLEN  ALU result, used as JALR target
- flush  in  1  redirect request
- flush_addr  in  XLEN  redirect target
- req_valid  out  1  fetch request valid
- req_ready  in  1  instruction memory accepts the request
- data  out  XLEN  current PC; also the request address
- branch  out  XLEN  data + dec_imm (combinational)
- ret  out  XLEN  data + ilen, where ilen = 2 if (C_EXT && ilen_c) else 4 (combinational)
- misalign_err  out  1  one-cycle pulse on a misaligned target
- halted  out  1  state is HALT
- retire_cnt  out  CNT_W  number of accepted op_valid updates

Behaviour:
- Reset, synchronous on rst=1 in any state including mid-handshake:
  - data=RESET_VECTOR, state=BOOT, req_valid=0, misalign_err=0, halted=0, retire_cnt=0.
- States:
  - BOOT: one cycle, then REQ.
  - REQ: req_valid=1. data is held stable while req_valid && !req_ready. When req_ready=1, go to EXEC the next cycle.
  - EXEC: req_valid=0; waits for op_valid.
  - HALT: req_valid=0, halted=1. Exits only via flush or rst.
- Next-PC selection in EXEC when op_valid=1:
  - PC_NEXT: ret.
  - PC_JAL: branch.
  - PC_JALR: {alu_res[XLEN-1:1], 1'b0}.
  - PC_BRANCH: br_taken ? branch : ret.
  - PC_HOLD: data unchanged; still counts as retire, re-fetches the same address.
  - Reserved codes 5-7: treated as PC_NEXT.
- Alignment: the target is misaligned if target[1]=1 when C_EXT=0, or target[0]=1 when C_EXT=1 (target[0] cannot be 1 after JALR masking).
  - Aligned target: data<=target, retire_cnt++, state REQ the next cycle (latency 1 cycle from op_valid to new data and req_valid).
  - Misaligned target: data unchanged, misalign_err=1 for one cycle, retire_cnt unchanged, state HALT.
- Flush:
  - Any state except while rst=1: data<=flush_addr, state REQ next cycle, misalign_err=0.
  - flush beats op_valid in the same cycle; no retire count for that cycle.
  - A flush during REQ abandons the outstanding request: req_valid stays 1 with the new address the next cycle.
  - Misaligned flush_addr: flush_addr[0] is forced to 0; when C_EXT=0, bit 1 is forced to 0 as well. No error is raised.
- Ignored inputs:
  - op_valid outside EXEC is ignored.
  - req_ready outside REQ is ignored.
- Arithmetic: all additions modulo 2^XLEN, so wrap-around is silent (e.g. 32'hFFFF_FFFC + 4 = 0). retire_cnt wraps at 2^CNT_W.

Decomposition:
- pc_pkg holds:
  - pc_op_e: PC_NEXT=0, PC_JAL=1, PC_JALR=2, PC_BRANCH=3, PC_HOLD=4.
  - pc_state_e: BOOT, REQ, EXEC, HALT.
  - Constants ILEN_16=2 and ILEN_32=4.
- One natural sub-module: pc_next_sel, the combinational target mux, adders and misalign check. The FSM, registers and counter stay in pc_fetch_ctrl.

Test Plan:
1. Reset: rst=1 for 2 cycles, RESET_VECTOR=32'h100 -> data=32'h100, req_valid=0 in BOOT, req_valid=1 the cycle after, retire_cnt=0.
2. Handshake stall: req_ready=0 for 3 cycles, then 1 -> data stable at 32'h100 with req_valid=1 throughout; EXEC the next cycle; op=PC_NEXT, op_valid=1 -> data=32'h104, retire_cnt=1.
3. Branch, C_EXT=1: data=32'h200, ilen_c=1, op=PC_BRANCH, br_taken=0 -> data=32'h202. Then dec_imm=32'hFFFF_FFF0, br_taken=1 -> data=32'h1F2.
4. Misalign, C_EXT=0: data=32'h300, op=PC_JAL, dec_imm=32'h6 -> misalign_err pulse for 1 cycle, data=32'h300, halted=1, retire_cnt unchanged. Then flush_addr=32'h400 -> halted=0, data=32'h400, req_valid=1.
5. Flush priority: in EXEC, flush=1 with flush_addr=32'h800 and op_valid=1 (op=PC_JAL) in the same cycle -> data=32'h800, retire_cnt unchanged.
6. Wrap and mid-operation reset: data=32'hFFFF_FFFC, op=PC_NEXT -> data=0. Then rst=1 during REQ with req_ready=0 -> next cycle data=RESET_VECTOR, req_valid=0, state BOOT.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter fetch controller.
//   pc_op_e    : PC update operation driven by execute (codes 5-7 reserved).
//   pc_state_e : fetch controller state.
//   ILEN_16/32 : byte increments for compressed / full-width instructions.
//   is_misaligned : alignment rule for a fetch target.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_NEXT   = 3'd0,
    PC_JAL    = 3'd1,
    PC_JALR   = 3'd2,
    PC_BRANCH = 3'd3,
    PC_HOLD   = 3'd4
  } pc_op_e;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } pc_state_e;

  localparam int unsigned ILEN_16 = 2;
  localparam int unsigned ILEN_32 = 4;

  // With compressed support only halfword alignment is required,
  // otherwise the target must sit on a word boundary.
  function automatic logic is_misaligned(input logic [1:0] low, input logic c_ext);
    return c_ext ? low[0] : low[1];
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: instruction-fetch request channel.
//   req_valid : fetch request valid (controller -> memory)
//   req_ready : memory accepts the request (memory -> controller)
//   data      : current PC, used as the request address (controller -> memory)
// master = fetch controller, slave = instruction memory port.
interface pc_fetch_ctrl_if #(
  parameter int XLEN = 32
) ();

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] data;

  modport master (
    output req_valid,
    output data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  data,
    output req_ready
  );

endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC selection.
//   op, br_taken, ilen_c   : operation controls from execute
//   pc                     : current architectural PC
//   dec_imm, alu_res       : immediate and JALR base target
//   branch                 : pc + dec_imm
//   ret                    : pc + instruction length (2 or 4)
//   target                 : selected next PC
//   misalign               : target violates instruction alignment
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int C_EXT = 0
) (
  input  logic [2:0]      op,
  input  logic            br_taken,
  input  logic            ilen_c,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] dec_imm,
  input  logic [XLEN-1:0] alu_res,
  output logic [XLEN-1:0] branch,
  output logic [XLEN-1:0] ret,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] ilen;
  logic            unused_alu_lsb;

  // Compressed length only takes effect when the extension is built in.
  assign ilen   = ((C_EXT != 0) && ilen_c) ? XLEN'(ILEN_16) : XLEN'(ILEN_32);
  assign branch = pc + dec_imm;
  assign ret    = pc + ilen;

  // JALR drops bit 0 of the computed address.
  assign unused_alu_lsb = alu_res[0];

  always_comb begin
    target = ret;
    case (op)
      PC_NEXT:   target = ret;
      PC_JAL:    target = branch;
      PC_JALR:   target = {alu_res[XLEN-1:1], 1'b0};
      PC_BRANCH: target = br_taken ? branch : ret;
      PC_HOLD:   target = pc;
      default:   target = ret;  // reserved codes behave as sequential
    endcase
  end

  assign misalign = is_misaligned(target[1:0], C_EXT != 0);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: architectural PC holder and fetch-request controller.
//   clk, rst        : clock, synchronous active-high reset
//   op, op_valid    : PC update from execute (accepted only in EXEC)
//   br_taken        : branch condition for PC_BRANCH
//   ilen_c          : current instruction is 16-bit (C_EXT builds only)
//   dec_imm         : decoded immediate
//   alu_res         : JALR target
//   flush/flush_addr: redirect request and target (any state)
//   fetch           : request channel (req_valid/req_ready/data)
//   branch, ret     : data + dec_imm, data + ilen (combinational)
//   misalign_err    : one-cycle pulse when a misaligned target is rejected
//   halted          : controller stopped after misalignment
//   retire_cnt      : count of accepted PC updates
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              C_EXT        = 0,
  parameter int              CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          op,
  input  logic                op_valid,
  input  logic                br_taken,
  input  logic                ilen_c,
  input  logic [XLEN-1:0]     dec_imm,
  input  logic [XLEN-1:0]     alu_res,
  input  logic                flush,
  input  logic [XLEN-1:0]     flush_addr,
  pc_fetch_ctrl_if.master     fetch,
  output logic [XLEN-1:0]     branch,
  output logic [XLEN-1:0]     ret,
  output logic                misalign_err,
  output logic                halted,
  output logic [CNT_W-1:0]    retire_cnt
);

  // Reject a reset vector the fetch path could never issue.
  localparam logic RV_BAD = (C_EXT != 0) ? RESET_VECTOR[0]
                                         : (RESET_VECTOR[1] | RESET_VECTOR[0]);
  if (RV_BAD) begin : g_rv_check
    $error("pc_fetch_ctrl: RESET_VECTOR is not instruction-aligned");
  end

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] target;
  logic            misalign;
  logic [XLEN-1:0] flush_target;
  logic            unused_flush_lsb;

  pc_next_sel #(
    .XLEN  (XLEN),
    .C_EXT (C_EXT)
  ) u_next_sel (
    .op       (op),
    .br_taken (br_taken),
    .ilen_c   (ilen_c),
    .pc       (pc_q),
    .dec_imm  (dec_imm),
    .alu_res  (alu_res),
    .branch   (branch),
    .ret      (ret),
    .target   (target),
    .misalign (misalign)
  );

  // Redirect targets are silently realigned rather than faulted.
  assign flush_target     = {flush_addr[XLEN-1:2],
                             (C_EXT != 0) ? flush_addr[1] : 1'b0,
                             1'b0};
  assign unused_flush_lsb = flush_addr[0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (flush) begin
      // Redirect overrides everything, including an op_valid in the same cycle.
      pc_d    = flush_target;
      state_d = REQ;
    end else begin
      case (state_q)
        BOOT: state_d = REQ;
        REQ: begin
          if (fetch.req_ready) state_d = EXEC;
        end
        EXEC: begin
          if (op_valid) begin
            if (misalign) begin
              err_d   = 1'b1;
              state_d = HALT;
            end else begin
              pc_d    = target;
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = REQ;
            end
          end
        end
        HALT:    state_d = HALT;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign fetch.req_valid = (state_q == REQ);
  assign fetch.data      = pc_q;
  assign halted          = (state_q == HALT);
  assign misalign_err    = err_q;
  assign retire_cnt      = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: two instances sharing stimulus, one built
// without (index 0) and one with (index 1) compressed-instruction support.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  op = 3'd0;
  logic        op_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic        ilen_c = 1'b0;
  logic [31:0] dec_imm = '0;
  logic [31:0] alu_res = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_addr = '0;
  logic        req_ready = 1'b0;

  logic [31:0] br_w   [2];
  logic [31:0] ret_w  [2];
  logic        err_w  [2];
  logic        halt_w [2];
  logic [31:0] cnt_w  [2];
  logic [31:0] data_w [2];
  logic        rv_w   [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.XLEN(32)) if0 ();
  pc_fetch_ctrl_if #(.XLEN(32)) if1 ();

  assign if0.req_ready = req_ready;
  assign if1.req_ready = req_ready;
  assign data_w[0] = if0.data;
  assign data_w[1] = if1.data;
  assign rv_w[0]   = if0.req_valid;
  assign rv_w[1]   = if1.req_valid;

  pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(RV), .C_EXT(0), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .op(op), .op_valid(op_valid), .br_taken(br_taken),
    .ilen_c(ilen_c), .dec_imm(dec_imm), .alu_res(alu_res), .flush(flush),
    .flush_addr(flush_addr), .fetch(if0.master), .branch(br_w[0]), .ret(ret_w[0]),
    .misalign_err(err_w[0]), .halted(halt_w[0]), .retire_cnt(cnt_w[0])
  );

  pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(RV), .C_EXT(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .op(op), .op_valid(op_valid), .br_taken(br_taken),
    .ilen_c(ilen_c), .dec_imm(dec_imm), .alu_res(alu_res), .flush(flush),
    .flush_addr(flush_addr), .fetch(if1.master), .branch(br_w[1]), .ret(ret_w[1]),
    .misalign_err(err_w[1]), .halted(halt_w[1]), .retire_cnt(cnt_w[1])
  );

  // Reference model: what the controller is doing, per instance.
  // k=0 has no compressed support, k=1 has it.
  localparam int PH_BOOT = 0, PH_REQ = 1, PH_EXEC = 2, PH_HALT = 3;
  logic [31:0] m_pc  [2];
  int          m_ph  [2];
  logic        m_err [2];
  logic [31:0] m_cnt [2];

  function automatic logic [31:0] m_ret(int k);
    return m_pc[k] + ((k == 1 && ilen_c) ? 32'd2 : 32'd4);
  endfunction

  function automatic logic [31:0] m_branch(int k);
    return m_pc[k] + dec_imm;
  endfunction

  function automatic logic [31:0] m_target(int k);
    case (op)
      3'd1:    return m_branch(k);
      3'd2:    return alu_res & 32'hFFFF_FFFE;
      3'd3:    return br_taken ? m_branch(k) : m_ret(k);
      3'd4:    return m_pc[k];
      default: return m_ret(k);
    endcase
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] t;
      logic        bad;
      t   = m_target(k);
      bad = (k == 1) ? t[0] : t[1];
      if (rst) begin
        m_pc[k] = RV; m_ph[k] = PH_BOOT; m_err[k] = 1'b0; m_cnt[k] = 32'd0;
      end else if (flush) begin
        m_pc[k]  = (k == 1) ? (flush_addr & 32'hFFFF_FFFE) : (flush_addr & 32'hFFFF_FFFC);
        m_ph[k]  = PH_REQ;
        m_err[k] = 1'b0;
      end else begin
        m_err[k] = 1'b0;
        if (m_ph[k] == PH_BOOT) m_ph[k] = PH_REQ;
        else if (m_ph[k] == PH_REQ) begin
          if (req_ready) m_ph[k] = PH_EXEC;
        end else if (m_ph[k] == PH_EXEC && op_valid) begin
          if (bad) begin
            m_err[k] = 1'b1; m_ph[k] = PH_HALT;
          end else begin
            m_pc[k] = t; m_cnt[k] = m_cnt[k] + 32'd1; m_ph[k] = PH_REQ;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic go_exec_at(input logic [31:0] addr);
    flush = 1'b1; flush_addr = addr; step();
    flush = 1'b0; req_ready = 1'b1; step();
    req_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    for (int k = 0; k < 2; k++) begin
      checks++; if (data_w[k] !== RV) begin errors++; $display("FAIL reset_data dut%0d got=%h exp=%h", k, data_w[k], RV); end
      checks++; if (rv_w[k] !== 1'b0) begin errors++; $display("FAIL reset_req_valid dut%0d got=%b exp=0", k, rv_w[k]); end
      checks++; if (halt_w[k] !== 1'b0) begin errors++; $display("FAIL reset_halted dut%0d got=%b exp=0", k, halt_w[k]); end
      checks++; if (err_w[k] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d got=%b exp=0", k, err_w[k]); end
      checks++; if (cnt_w[k] !== 32'd0) begin errors++; $display("FAIL reset_cnt dut%0d got=%0d exp=0", k, cnt_w[k]); end
    end
    rst = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++; if (rv_w[k] !== 1'b1) begin errors++; $display("FAIL boot_to_req dut%0d got=%b exp=1", k, rv_w[k]); end
    end
  endtask

  task automatic test_handshake_stall();
    req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++; if (data_w[k] !== RV || rv_w[k] !== 1'b1) begin errors++;
          $display("FAIL stall_hold dut%0d cyc%0d got=%h/%b exp=%h/1", k, c, data_w[k], rv_w[k], RV); end
      end
    end
    req_ready = 1'b1; step(); req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (rv_w[k] !== 1'b0) begin errors++; $display("FAIL stall_exec dut%0d got=%b exp=0", k, rv_w[k]); end
    end
    op = 3'd0; ilen_c = 1'b0; op_valid = 1'b1; step(); op_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (data_w[k] !== 32'h104) begin errors++; $display("FAIL next_data dut%0d got=%h exp=00000104", k, data_w[k]); end
      checks++; if (cnt_w[k] !== 32'd1) begin errors++; $display("FAIL next_cnt dut%0d got=%0d exp=1", k, cnt_w[k]); end
      checks++; if (rv_w[k] !== 1'b1) begin errors++; $display("FAIL next_req dut%0d got=%b exp=1", k, rv_w[k]); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] exp_a [2];
    logic [31:0] exp_b [2];
    exp_a[0] = 32'h204; exp_a[1] = 32'h202;
    exp_b[0] = 32'h1F4; exp_b[1] = 32'h1F2;
    go_exec_at(32'h200);
    ilen_c = 1'b1; op = 3'd3; br_taken = 1'b0; dec_imm = 32'h10; op_valid = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (ret_w[k] !== exp_a[k]) begin errors++; $display("FAIL ret_comb dut%0d got=%h exp=%h", k, ret_w[k], exp_a[k]); end
      checks++; if (br_w[k] !== 32'h210) begin errors++; $display("FAIL branch_comb dut%0d got=%h exp=00000210", k, br_w[k]); end
    end
    step(); op_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (data_w[k] !== exp_a[k]) begin errors++; $display("FAIL br_not_taken dut%0d got=%h exp=%h", k, data_w[k], exp_a[k]); end
    end
    req_ready = 1'b1; step(); req_ready = 1'b0;
    dec_imm = 32'hFFFF_FFF0; br_taken = 1'b1; op_valid = 1'b1; step(); op_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (data_w[k] !== exp_b[k]) begin errors++; $display("FAIL br_taken dut%0d got=%h exp=%h", k, data_w[k], exp_b[k]); end
      checks++; if (cnt_w[k] !== 32'd3) begin errors++; $display("FAIL br_cnt dut%0d got=%0d exp=3", k, cnt_w[k]); end
    end
    ilen_c = 1'b0; br_taken = 1'b0;
  endtask

  task automatic test_misalign();
    go_exec_at(32'h300);
    op = 3'd1; dec_imm = 32'h6; op_valid = 1'b1; step(); op_valid = 1'b0;
    checks++; if (err_w[0] !== 1'b1) begin errors++; $display("FAIL mis_err dut0 got=%b exp=1", err_w[0]); end
    checks++; if (halt_w[0] !== 1'b1) begin errors++; $display("FAIL mis_halt dut0 got=%b exp=1", halt_w[0]); end
    checks++; if (data_w[0] !== 32'h300) begin errors++; $display("FAIL mis_data dut0 got=%h exp=00000300", data_w[0]); end
    checks++; if (cnt_w[0] !== 32'd3) begin errors++; $display("FAIL mis_cnt dut0 got=%0d exp=3", cnt_w[0]); end
    checks++; if (data_w[1] !== 32'h306 || err_w[1] !== 1'b0) begin errors++;
      $display("FAIL half_align dut1 got=%h/%b exp=00000306/0", data_w[1], err_w[1]); end
    step();
    checks++; if (err_w[0] !== 1'b0 || halt_w[0] !== 1'b1) begin errors++;
      $display("FAIL mis_pulse dut0 err/halt got=%b/%b exp=0/1", err_w[0], halt_w[0]); end
    flush = 1'b1; flush_addr = 32'h400; step();
    checks++; if (halt_w[0] !== 1'b0 || data_w[0] !== 32'h400 || rv_w[0] !== 1'b1) begin errors++;
      $display("FAIL halt_flush dut0 got=%b/%h/%b exp=0/00000400/1", halt_w[0], data_w[0], rv_w[0]); end
    flush_addr = 32'h403; step(); flush = 1'b0;
    checks++; if (data_w[0] !== 32'h400) begin errors++; $display("FAIL flush_mask dut0 got=%h exp=00000400", data_w[0]); end
    checks++; if (data_w[1] !== 32'h402) begin errors++; $display("FAIL flush_mask dut1 got=%h exp=00000402", data_w[1]); end
  endtask

  task automatic test_flush_priority();
    logic [31:0] c0 [2];
    req_ready = 1'b1; step(); req_ready = 1'b0;
    c0[0] = m_cnt[0]; c0[1] = m_cnt[1];
    flush = 1'b1; flush_addr = 32'h800; op = 3'd1; dec_imm = 32'h40; op_valid = 1'b1;
    step(); flush = 1'b0; op_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (data_w[k] !== 32'h800) begin errors++; $display("FAIL flush_prio_data dut%0d got=%h exp=00000800", k, data_w[k]); end
      checks++; if (cnt_w[k] !== c0[k]) begin errors++; $display("FAIL flush_prio_cnt dut%0d got=%0d exp=%0d", k, cnt_w[k], c0[k]); end
    end
  endtask

  task automatic test_wrap_reset();
    go_exec_at(32'hFFFF_FFFC);
    op = 3'd0; ilen_c = 1'b0; op_valid = 1'b1; step(); op_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (data_w[k] !== 32'h0) begin errors++; $display("FAIL wrap dut%0d got=%h exp=00000000", k, data_w[k]); end
    end
    req_ready = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (data_w[k] !== RV || rv_w[k] !== 1'b0 || cnt_w[k] !== 32'd0) begin errors++;
        $display("FAIL mid_reset dut%0d got=%h/%b/%0d exp=%h/0/0", k, data_w[k], rv_w[k], cnt_w[k], RV); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      flush      = ($urandom_range(0, 11) == 0);
      flush_addr = $urandom;
      req_ready  = $urandom_range(0, 1);
      op_valid   = $urandom_range(0, 1);
      op         = 3'($urandom_range(0, 7));
      br_taken   = $urandom_range(0, 1);
      ilen_c     = $urandom_range(0, 1);
      dec_imm    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63)) - 32'd32;
      alu_res    = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++; if (br_w[k] !== m_branch(k) || ret_w[k] !== m_ret(k)) begin errors++;
          $display("FAIL rnd_comb dut%0d n%0d got=%h/%h exp=%h/%h", k, n, br_w[k], ret_w[k], m_branch(k), m_ret(k)); end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (data_w[k] !== m_pc[k] || rv_w[k] !== (m_ph[k] == PH_REQ) ||
            halt_w[k] !== (m_ph[k] == PH_HALT) || err_w[k] !== m_err[k] || cnt_w[k] !== m_cnt[k]) begin
          errors++;
          $display("FAIL rnd_state dut%0d n%0d got pc=%h rv=%b h=%b e=%b c=%0d exp pc=%h rv=%b h=%b e=%b c=%0d",
                   k, n, data_w[k], rv_w[k], halt_w[k], err_w[k], cnt_w[k],
                   m_pc[k], (m_ph[k] == PH_REQ), (m_ph[k] == PH_HALT), m_err[k], m_cnt[k]);
        end
      end
    end
    rst = 1'b0; flush = 1'b0; op_valid = 1'b0; req_ready = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = RV; m_ph[k] = PH_BOOT; m_err[k] = 1'b0; m_cnt[k] = 32'd0;
    end
    test_reset();
    test_handshake_stall();
    test_branch();
    test_misalign();
    test_flush_priority();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
